// File: rtl/simon_seq_game.sv
// Simon sequence-memory engine: grows a pseudo-random button sequence each round,
// plays it back as timed press/release pulses and checks the player's entries.
module simon_seq_game #(
    parameter int          BTN_W         = 2,
    parameter int          MAX_LEN       = 16,
    parameter int          ON_TICKS      = 30,
    parameter int          OFF_TICKS     = 30,
    parameter int          TIMEOUT_TICKS = 300,
    parameter logic [15:0] SEED          = 16'hACE1,
    localparam int         LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BTN_W-1:0] player_num,
    input  logic             player_pressed,
    output logic             simon_turn,
    output logic [BTN_W-1:0] simon_num,
    output logic             simon_pressed,
    output logic [LEN_W-1:0] round_len,
    output logic [LEN_W-1:0] score,
    output logic             game_over,
    output logic             game_won
);

    localparam int               IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [15:0]      SEED_EFF    = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [15:0]      ON_LAST     = 16'(ON_TICKS - 1);
    localparam logic [15:0]      OFF_LAST    = 16'(OFF_TICKS - 1);
    localparam logic [15:0]      TIMEOUT_VAL = 16'(TIMEOUT_TICKS);
    localparam logic [LEN_W-1:0] MAX_LEN_V   = LEN_W'(MAX_LEN);

    typedef enum logic [3:0] {
        S_IDLE, S_GEN, S_SHOW_ON, S_SHOW_OFF, S_WAIT_PRESS,
        S_WAIT_RELEASE, S_CHECK, S_OVER, S_WON
    } state_t;

    function automatic logic [15:0] lfsr_next(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    state_t           state_r, state_nxt_s;
    logic [BTN_W-1:0] seq_r [MAX_LEN];
    logic [15:0]      lfsr_r, lfsr_nxt_s;
    logic [LEN_W-1:0] idx_r, idx_nxt_s;
    logic [15:0]      timer_r, timer_nxt_s, timer_inc_s;
    logic [BTN_W-1:0] cap_r, cap_nxt_s;
    logic             seq_we_s;
    logic             turn_nxt_s, pressed_nxt_s, over_nxt_s, won_nxt_s;
    logic [BTN_W-1:0] num_nxt_s, seq_at_idx_s;
    logic [LEN_W-1:0] len_nxt_s, score_nxt_s;
    logic             idx_last_s;

    assign timer_inc_s  = timer_r + 16'd1;
    assign seq_at_idx_s = seq_r[idx_r[IDX_W-1:0]];
    assign idx_last_s   = (idx_r == (round_len - LEN_W'(1)));

    // Next-state and next-output computation for every registered value
    always_comb begin
        state_nxt_s   = state_r;
        lfsr_nxt_s    = lfsr_r;
        idx_nxt_s     = idx_r;
        timer_nxt_s   = timer_r;
        cap_nxt_s     = cap_r;
        seq_we_s      = 1'b0;
        turn_nxt_s    = simon_turn;
        num_nxt_s     = simon_num;
        pressed_nxt_s = simon_pressed;
        len_nxt_s     = round_len;
        score_nxt_s   = score;
        over_nxt_s    = game_over;
        won_nxt_s     = game_won;
        case (state_r)
            S_IDLE, S_OVER, S_WON: begin
                turn_nxt_s    = 1'b0;
                pressed_nxt_s = 1'b0;
                if (start) begin
                    len_nxt_s   = '0;
                    score_nxt_s = '0;
                    over_nxt_s  = 1'b0;
                    won_nxt_s   = 1'b0;
                    state_nxt_s = S_GEN;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            S_GEN: begin
                seq_we_s    = 1'b1;
                lfsr_nxt_s  = lfsr_next(lfsr_r);
                len_nxt_s   = round_len + LEN_W'(1);
                idx_nxt_s   = '0;
                timer_nxt_s = 16'd0;
                turn_nxt_s  = 1'b1;
                state_nxt_s = S_SHOW_ON;
            end
            S_SHOW_ON: begin
                pressed_nxt_s = 1'b1;
                num_nxt_s     = seq_at_idx_s;
                if (timer_r == ON_LAST) begin
                    timer_nxt_s = 16'd0;
                    state_nxt_s = S_SHOW_OFF;
                end else begin
                    timer_nxt_s = timer_inc_s;
                end
            end
            S_SHOW_OFF: begin
                pressed_nxt_s = 1'b0;
                if (timer_r == OFF_LAST) begin
                    timer_nxt_s = 16'd0;
                    if (idx_last_s) begin
                        idx_nxt_s   = '0;
                        turn_nxt_s  = 1'b0;
                        state_nxt_s = S_WAIT_PRESS;
                    end else begin
                        idx_nxt_s   = idx_r + LEN_W'(1);
                        state_nxt_s = S_SHOW_ON;
                    end
                end else begin
                    timer_nxt_s = timer_inc_s;
                end
            end
            S_WAIT_PRESS: begin
                if (player_pressed) begin
                    cap_nxt_s   = player_num;
                    state_nxt_s = S_WAIT_RELEASE;
                end else begin
                    timer_nxt_s = timer_inc_s;
                    // A zero timeout never expires; the timer is then free-running
                    if ((TIMEOUT_VAL != 16'd0) && (timer_inc_s == TIMEOUT_VAL)) begin
                        over_nxt_s  = 1'b1;
                        state_nxt_s = S_OVER;
                    end else begin
                        state_nxt_s = S_WAIT_PRESS;
                    end
                end
            end
            S_WAIT_RELEASE: begin
                if (!player_pressed) begin
                    state_nxt_s = S_CHECK;
                end else begin
                    state_nxt_s = S_WAIT_RELEASE;
                end
            end
            S_CHECK: begin
                if (cap_r != seq_at_idx_s) begin
                    over_nxt_s  = 1'b1;
                    state_nxt_s = S_OVER;
                end else if (!idx_last_s) begin
                    idx_nxt_s   = idx_r + LEN_W'(1);
                    timer_nxt_s = 16'd0;
                    state_nxt_s = S_WAIT_PRESS;
                end else begin
                    score_nxt_s = round_len;
                    if (round_len == MAX_LEN_V) begin
                        won_nxt_s   = 1'b1;
                        state_nxt_s = S_WON;
                    end else begin
                        state_nxt_s = S_GEN;
                    end
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r       <= S_IDLE;
            lfsr_r        <= SEED_EFF;
            idx_r         <= '0;
            timer_r       <= 16'd0;
            cap_r         <= '0;
            simon_turn    <= 1'b0;
            simon_num     <= '0;
            simon_pressed <= 1'b0;
            round_len     <= '0;
            score         <= '0;
            game_over     <= 1'b0;
            game_won      <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seq_r[i] <= '0;
            end
        end else begin
            state_r       <= state_nxt_s;
            lfsr_r        <= lfsr_nxt_s;
            idx_r         <= idx_nxt_s;
            timer_r       <= timer_nxt_s;
            cap_r         <= cap_nxt_s;
            simon_turn    <= turn_nxt_s;
            simon_num     <= num_nxt_s;
            simon_pressed <= pressed_nxt_s;
            round_len     <= len_nxt_s;
            score         <= score_nxt_s;
            game_over     <= over_nxt_s;
            game_won      <= won_nxt_s;
            if (seq_we_s) begin
                seq_r[round_len[IDX_W-1:0]] <= lfsr_r[BTN_W-1:0];
            end
        end
    end

endmodule
